uart_recv: RTL and testbench



---
 rtl/uart_recv.sv | 165 ++++++++++++++++
 tb/tb_uart_recv.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_recv.sv
// 8N1 UART receiver on the 16x-baud clock. Each committed byte is handed to the
// consumer through a remote_st/local_st toggle pair; errors are sticky until acked.
module uart_recv #(
   parameter int OVERSAMPLE   = 16,
   parameter int SAMPLE_POINT = 7
) (
   input  logic       clk_uart16,
   input  logic       rst_n,
   input  logic       rx,
   input  logic       local_st,
   output logic [7:0] data,
   output logic       remote_st,
   output logic       overrun,
   output logic       frame_err,
   output logic       busy
);

   localparam int CNT_W = $clog2(OVERSAMPLE);
   localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(OVERSAMPLE - 1);
   localparam logic [CNT_W-1:0] CNT_SAMPLE = CNT_W'(SAMPLE_POINT);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_BREAK
   } state_t;

   logic rx_meta_q, rx_s_q;
   logic ack_meta_q, ack_s_q, ack_d_q;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       bit_idx_q, bit_idx_d;
   logic [7:0]       shreg_q, shreg_d;
   logic [7:0]       data_q, data_d;
   logic             remote_st_q, remote_st_d;
   logic             overrun_q, overrun_d;
   logic             frame_err_q, frame_err_d;

   logic ack_edge, pending;

   assign ack_edge = ack_s_q ^ ack_d_q;
   assign pending  = remote_st_q != ack_s_q;

   // rx idles high, so its synchroniser resets to 1 to avoid a fake start bit.
   always_ff @(posedge clk_uart16) begin
      if (!rst_n) begin
         rx_meta_q  <= 1'b1;
         rx_s_q     <= 1'b1;
         ack_meta_q <= 1'b0;
         ack_s_q    <= 1'b0;
         ack_d_q    <= 1'b0;
      end else begin
         rx_meta_q  <= rx;
         rx_s_q     <= rx_meta_q;
         ack_meta_q <= local_st;
         ack_s_q    <= ack_meta_q;
         ack_d_q    <= ack_s_q;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      bit_idx_d   = bit_idx_q;
      shreg_d     = shreg_q;
      data_d      = data_q;
      remote_st_d = remote_st_q;
      overrun_d   = overrun_q;
      frame_err_d = frame_err_q;

      // Clear first so an error raised by the FSM on the same edge takes priority.
      if (ack_edge) begin
         overrun_d   = 1'b0;
         frame_err_d = 1'b0;
      end

      case (state_q)
         S_IDLE: begin
            if (!rx_s_q) begin
               state_d = S_START;
               cnt_d   = '0;
            end
         end
         S_START: begin
            if (cnt_q == CNT_SAMPLE) begin
               cnt_d     = '0;
               bit_idx_d = '0;
               state_d   = rx_s_q ? S_IDLE : S_DATA;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_DATA: begin
            if (cnt_q == CNT_LAST) begin
               shreg_d   = {rx_s_q, shreg_q[7:1]};
               cnt_d     = '0;
               bit_idx_d = bit_idx_q + 3'd1;
               if (bit_idx_q == 3'd7) begin
                  state_d = S_STOP;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_STOP: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d = '0;
               if (!rx_s_q) begin
                  frame_err_d = 1'b1;
                  state_d     = S_BREAK;
               end else if (pending) begin
                  overrun_d = 1'b1;
                  state_d   = S_IDLE;
               end else begin
                  data_d      = shreg_q;
                  remote_st_d = ~remote_st_q;
                  state_d     = S_IDLE;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_BREAK: begin
            if (rx_s_q) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_uart16) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         bit_idx_q   <= '0;
         shreg_q     <= '0;
         data_q      <= '0;
         remote_st_q <= 1'b0;
         overrun_q   <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         bit_idx_q   <= bit_idx_d;
         shreg_q     <= shreg_d;
         data_q      <= data_d;
         remote_st_q <= remote_st_d;
         overrun_q   <= overrun_d;
         frame_err_q <= frame_err_d;
      end
   end

   assign data      = data_q;
   assign remote_st = remote_st_q;
   assign overrun   = overrun_q;
   assign frame_err = frame_err_q;
   assign busy      = state_q != S_IDLE;

endmodule

// File: tb/tb_uart_recv.sv
// Bench for uart_recv: directed scenarios plus randomized frames, checked against
// a frame-level model of the consumer-visible outputs.
module tb_uart_recv;

   logic       clk_uart16 = 1'b0;
   logic       rst_n      = 1'b0;
   logic       rx         = 1'b1;
   logic       local_st   = 1'b0;
   logic [7:0] data;
   logic       remote_st;
   logic       overrun;
   logic       frame_err;
   logic       busy;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: what the consumer should see after each whole frame.
   logic [7:0] m_data   = 8'h00;
   logic       m_remote = 1'b0;
   logic       m_ovr    = 1'b0;
   logic       m_ferr   = 1'b0;

   uart_recv #(
      .OVERSAMPLE  (16),
      .SAMPLE_POINT(7)
   ) dut (
      .clk_uart16(clk_uart16),
      .rst_n     (rst_n),
      .rx        (rx),
      .local_st  (local_st),
      .data      (data),
      .remote_st (remote_st),
      .overrun   (overrun),
      .frame_err (frame_err),
      .busy      (busy)
   );

   always #5 clk_uart16 = ~clk_uart16;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic clocks(input int n);
      repeat (n) @(negedge clk_uart16);
   endtask

   task automatic check_state(input string tag);
      check_val({tag, ".data"}, 32'(data), 32'(m_data));
      check_val({tag, ".remote_st"}, 32'(remote_st), 32'(m_remote));
      check_val({tag, ".overrun"}, 32'(overrun), 32'(m_ovr));
      check_val({tag, ".frame_err"}, 32'(frame_err), 32'(m_ferr));
   endtask

   // Whole 160-clock frame; the stop sample lands a few clocks before it ends.
   task automatic send_frame(input logic [7:0] b, input logic stop);
      rx = 1'b0;
      clocks(16);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         clocks(16);
      end
      rx = stop;
      clocks(16);
      if (!stop) begin
         m_ferr = 1'b1;
      end else if (m_remote != local_st) begin
         m_ovr = 1'b1;
      end else begin
         m_data   = b;
         m_remote = ~m_remote;
      end
      $display("frame byte=0x%02h stop=%0d -> data=0x%02h remote_st=%0d", b, stop, data, remote_st);
   endtask

   task automatic ack();
      if (local_st != m_remote) begin
         m_ovr  = 1'b0;
         m_ferr = 1'b0;
      end
      local_st = m_remote;
      $display("ack local_st=%0d", local_st);
   endtask

   task automatic pulse_reset();
      rst_n    = 1'b0;
      local_st = 1'b0;
      clocks(1);
      rst_n    = 1'b1;
      m_data   = 8'h00;
      m_remote = 1'b0;
      m_ovr    = 1'b0;
      m_ferr   = 1'b0;
   endtask

   initial begin
      logic [7:0] rb;
      logic       rs;

      clocks(3);
      rst_n = 1'b1;
      clocks(2);
      check_state("reset");
      check_val("reset.busy", 32'(busy), 32'd0);

      send_frame(8'hA5, 1'b1);
      clocks(2);
      check_state("a5");
      check_val("a5.busy", 32'(busy), 32'd0);

      rx = 1'b0;
      clocks(4);
      rx = 1'b1;
      clocks(20);
      check_state("glitch");
      check_val("glitch.busy", 32'(busy), 32'd0);

      send_frame(8'h3C, 1'b0);
      clocks(40);
      check_state("ferr");
      check_val("ferr.busy_break", 32'(busy), 32'd1);
      rx = 1'b1;
      clocks(4);
      check_val("ferr.busy_exit", 32'(busy), 32'd0);
      ack();
      clocks(3);
      check_state("ferr_clear");
      send_frame(8'h11, 1'b1);
      clocks(2);
      check_state("after_ferr");
      ack();
      clocks(4);

      send_frame(8'h01, 1'b1);
      send_frame(8'h02, 1'b1);
      clocks(2);
      check_state("overrun");
      ack();
      clocks(4);
      check_state("overrun_clear");

      rx = 1'b0;
      clocks(16);
      for (int i = 0; i < 4; i++) begin
         rx = 8'h5A >> i;
         clocks(16);
      end
      rx = 1'b1;
      clocks(8);
      pulse_reset();
      clocks(30);
      check_state("midreset");
      check_val("midreset.busy", 32'(busy), 32'd0);
      send_frame(8'hC3, 1'b1);
      clocks(2);
      check_state("c3");
      ack();
      clocks(4);

      send_frame(8'h00, 1'b1);
      check_state("b2b_00");
      ack();
      send_frame(8'hFF, 1'b1);
      check_state("b2b_ff");
      ack();
      clocks(4);
      check_state("b2b_acked");

      for (int it = 0; it < 24; it++) begin
         rb = 8'($urandom);
         rs = $urandom_range(0, 5) != 0;
         send_frame(rb, rs);
         if (!rs) begin
            clocks(int'($urandom_range(0, 30)));
            check_val("rnd.busy_break", 32'(busy), 32'd1);
            rx = 1'b1;
            clocks(4);
         end else begin
            clocks(2);
         end
         check_state("rnd");
         check_val("rnd.busy", 32'(busy), 32'd0);
         if ($urandom_range(0, 1) != 0) begin
            ack();
            clocks(4);
            check_state("rnd.ack");
         end
         clocks(int'($urandom_range(0, 5)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
